// File: rtl/cpu_clock_ctrl.sv
// CPU clock-enable generator: prescaled one-clk cpu_ce pulse with
// run / cycle-step / instruction-step / breakpoint control and cycle count.
module cpu_clock_ctrl #(
   parameter int DIV_W  = 17,
   parameter int ADDR_W = 16,
   parameter int CYC_W  = 32
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic [DIV_W-1:0]  i_div_ratio,
   input  logic [1:0]        i_mode,
   input  logic              i_step_req,
   input  logic              i_bp_en,
   input  logic [ADDR_W-1:0] i_bp_addr,
   input  logic              i_bp_clr,
   input  logic [ADDR_W-1:0] i_cpu_addr,
   input  logic              i_cpu_sync,
   output logic              o_cpu_ce,
   output logic              o_halted,
   output logic              o_bp_hit,
   output logic [CYC_W-1:0]  o_cycle_count
);

   localparam logic [1:0] M_RUN   = 2'b00;
   localparam logic [1:0] M_CYC   = 2'b01;
   localparam logic [1:0] M_INSTR = 2'b10;
   localparam logic [1:0] M_HALT  = 2'b11;

   typedef enum logic [1:0] {
      S_PAUSED,
      S_RUNNING,
      S_STEPPING
   } state_t;

   state_t            r_state;
   state_t            w_next;
   logic [DIV_W-1:0]  r_cnt;
   logic              r_ce;
   logic              r_halted;
   logic              r_bp_hit;
   logic [CYC_W-1:0]  r_cyc;
   logic              r_skip;
   logic              r_step_q;
   logic              r_kind_instr;
   logic              r_first_done;

   logic              w_tick;
   logic              w_edge;
   logic              w_bp;
   logic              w_issue;
   logic              w_set_bp;
   logic              w_enter_step;

   // >= rather than == so a lowered ratio never wraps the counter
   assign w_tick = (r_cnt >= i_div_ratio);
   assign w_edge = i_step_req & ~r_step_q;
   assign w_bp   = i_bp_en & i_cpu_sync
                 & (i_cpu_addr == i_bp_addr) & ~r_skip;

   always_comb begin
      w_next       = r_state;
      w_issue      = 1'b0;
      w_set_bp     = 1'b0;
      w_enter_step = 1'b0;
      unique case (r_state)
         S_PAUSED: begin
            if (i_mode == M_RUN && !r_bp_hit) begin
               w_next = S_RUNNING;
            end else if ((i_mode == M_CYC || i_mode == M_INSTR) && w_edge) begin
               w_next       = S_STEPPING;
               w_enter_step = 1'b1;
            end
         end
         S_RUNNING: begin
            if (i_mode != M_RUN) begin
               w_next = S_PAUSED;
            end else if (w_tick) begin
               if (w_bp) begin
                  w_set_bp = 1'b1;
                  w_next   = S_PAUSED;
               end else begin
                  w_issue = 1'b1;
               end
            end
         end
         S_STEPPING: begin
            if (i_mode == M_HALT) begin
               w_next = S_PAUSED;
            end else if (w_tick) begin
               if (!r_kind_instr) begin
                  w_issue = 1'b1;
                  w_next  = S_PAUSED;
               end else if (!r_first_done || !i_cpu_sync) begin
                  w_issue = 1'b1;
               end else begin
                  w_next = S_PAUSED;
               end
            end
         end
         default: w_next = S_PAUSED;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_cnt        <= '0;
         r_state      <= S_PAUSED;
         r_ce         <= 1'b0;
         r_halted     <= 1'b1;
         r_bp_hit     <= 1'b0;
         r_cyc        <= '0;
         r_skip       <= 1'b0;
         r_step_q     <= 1'b0;
         r_kind_instr <= 1'b0;
         r_first_done <= 1'b0;
      end else begin
         r_cnt    <= w_tick ? '0 : r_cnt + {{(DIV_W-1){1'b0}}, 1'b1};
         r_state  <= w_next;
         r_ce     <= w_issue;
         r_halted <= (w_next == S_PAUSED);
         r_cyc    <= r_cyc + {{(CYC_W-1){1'b0}}, w_issue};
         r_step_q <= i_step_req;
         if (w_set_bp) begin
            r_bp_hit <= 1'b1;
         end else if (i_bp_clr) begin
            r_bp_hit <= 1'b0;
         end
         // skip masks the breakpoint we may be resuming from
         if (r_state == S_PAUSED && w_next != S_PAUSED) begin
            r_skip <= 1'b1;
         end else if (w_issue) begin
            r_skip <= 1'b0;
         end
         if (w_enter_step) begin
            r_kind_instr <= (i_mode == M_INSTR);
            r_first_done <= 1'b0;
         end else if (w_issue) begin
            r_first_done <= 1'b1;
         end
      end
   end

   assign o_cpu_ce      = r_ce;
   assign o_halted      = r_halted;
   assign o_bp_hit      = r_bp_hit;
   assign o_cycle_count = r_cyc;

endmodule

// File: tb/tb_cpu_clock_ctrl.sv
// Directed bench for cpu_clock_ctrl: run, ratio change, breakpoint,
// cycle/instruction stepping and asynchronous reset.
module tb_cpu_clock_ctrl;

   logic        clk;
   logic        rst;
   logic [16:0] div_ratio;
   logic [1:0]  mode;
   logic        step_req;
   logic        bp_en;
   logic [15:0] bp_addr;
   logic        bp_clr;
   logic [15:0] cpu_addr;
   logic        cpu_sync;
   logic        cpu_ce;
   logic        halted;
   logic        bp_hit;
   logic [31:0] cycle_count;

   int n_checks = 0;
   int n_fail   = 0;

   cpu_clock_ctrl #(.DIV_W(17), .ADDR_W(16), .CYC_W(32)) dut (
      .i_clk         (clk),
      .i_rst         (rst),
      .i_div_ratio   (div_ratio),
      .i_mode        (mode),
      .i_step_req    (step_req),
      .i_bp_en       (bp_en),
      .i_bp_addr     (bp_addr),
      .i_bp_clr      (bp_clr),
      .i_cpu_addr    (cpu_addr),
      .i_cpu_sync    (cpu_sync),
      .o_cpu_ce      (cpu_ce),
      .o_halted      (halted),
      .o_bp_hit      (bp_hit),
      .o_cycle_count (cycle_count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [63:0] obs,
                        input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic clk_n(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      int errs;
      int ces;
      rst       = 1'b1;
      div_ratio = 17'd3;
      mode      = 2'b00;
      step_req  = 1'b0;
      bp_en     = 1'b0;
      bp_addr   = 16'h0203;
      bp_clr    = 1'b0;
      cpu_addr  = 16'h0000;
      cpu_sync  = 1'b0;

      clk_n(3);
      check("rst_ce", cpu_ce, 0);
      check("rst_halted", halted, 1);
      check("rst_bp_hit", bp_hit, 0);
      check("rst_count", cycle_count, 0);

      // RUN at div 3: ce after edges 4, 8, ... 40
      rst  = 1'b0;
      errs = 0;
      for (int k = 1; k <= 40; k++) begin
         clk_n(1);
         if (cpu_ce !== ((k % 4) == 0)) errs++;
      end
      check("run_pattern", errs, 0);
      check("run_count", cycle_count, 10);
      check("run_halted", halted, 0);

      // slow ratio, then drop below cnt mid-count
      div_ratio = 17'd1000;
      clk_n(500);
      check("slow_count", cycle_count, 10);
      check("slow_ce", cpu_ce, 0);
      div_ratio = 17'd2;
      clk_n(1);
      check("drop_ce", cpu_ce, 1);
      check("drop_count", cycle_count, 11);
      errs = 0;
      for (int k = 1; k <= 9; k++) begin
         clk_n(1);
         if (cpu_ce !== ((k % 3) == 0)) errs++;
      end
      check("drop_pattern", errs, 0);
      check("drop_count2", cycle_count, 14);

      // breakpoint hit on the next tick
      bp_en    = 1'b1;
      cpu_addr = 16'h0203;
      cpu_sync = 1'b1;
      clk_n(3);
      check("bp_ce", cpu_ce, 0);
      check("bp_hit", bp_hit, 1);
      check("bp_halted", halted, 1);
      clk_n(6);
      check("bp_frozen", cycle_count, 14);
      check("bp_still_halted", halted, 1);
      bp_clr = 1'b1;
      clk_n(1);
      bp_clr = 1'b0;
      check("bpclr_hit", bp_hit, 0);
      check("bpclr_halted", halted, 1);
      clk_n(1);
      check("resume_halted", halted, 0);
      clk_n(1);
      check("resume_ce", cpu_ce, 1);
      check("resume_count", cycle_count, 15);
      // second hit while bp_clr is held: the hit wins
      bp_clr = 1'b1;
      clk_n(3);
      check("rehit_ce", cpu_ce, 0);
      check("rehit_bp", bp_hit, 1);
      check("rehit_halted", halted, 1);
      check("rehit_count", cycle_count, 15);
      bp_clr = 1'b0;

      // cycle stepping, div 0
      bp_en     = 1'b0;
      cpu_sync  = 1'b0;
      div_ratio = 17'd0;
      mode      = 2'b01;
      ces       = 0;
      for (int s = 0; s < 3; s++) begin
         step_req = 1'b1;
         for (int k = 0; k < 10; k++) begin
            clk_n(1);
            if (cpu_ce) ces++;
         end
         step_req = 1'b0;
         for (int k = 0; k < 10; k++) begin
            clk_n(1);
            if (cpu_ce) ces++;
         end
         check("stepc_halted", halted, 1);
         check("stepc_count", cycle_count, 16 + s);
      end
      check("stepc_total", ces, 3);

      // instruction step, sync 1,0,0,1 on successive ticks
      mode     = 2'b10;
      step_req = 1'b1;
      clk_n(1);
      check("stepi_start_ce", cpu_ce, 0);
      check("stepi_start_halted", halted, 0);
      cpu_sync = 1'b1;
      clk_n(1);
      check("stepi_ce1", cpu_ce, 1);
      cpu_sync = 1'b0;
      clk_n(1);
      check("stepi_ce2", cpu_ce, 1);
      clk_n(1);
      check("stepi_ce3", cpu_ce, 1);
      cpu_sync = 1'b1;
      clk_n(1);
      check("stepi_stop_ce", cpu_ce, 0);
      check("stepi_halted", halted, 1);
      check("stepi_count", cycle_count, 21);
      step_req = 1'b0;
      clk_n(5);
      check("stepi_idle_count", cycle_count, 21);

      // run up to 57 cycles then reset asynchronously
      cpu_sync = 1'b0;
      mode     = 2'b00;
      bp_clr   = 1'b1;
      clk_n(1);
      bp_clr = 1'b0;
      check("pre_rst_bp", bp_hit, 0);
      clk_n(37);
      check("pre_rst_count", cycle_count, 57);
      check("pre_rst_ce", cpu_ce, 1);
      #2;
      rst = 1'b1;
      #1;
      check("arst_ce", cpu_ce, 0);
      check("arst_count", cycle_count, 0);
      check("arst_halted", halted, 1);
      clk_n(2);
      rst = 1'b0;
      clk_n(10);
      check("post_rst_count", cycle_count, 9);
      check("post_rst_halted", halted, 0);
      check("post_rst_ce", cpu_ce, 1);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/cpu_clock_ctrl.md
Name: cpu_clock_ctrl

Overview:
- Parametrised CPU clock-enable generator with run/step/breakpoint control; replaces the fixed divfactor clock divider in the CPU top level.
- Produces a single-cycle enable pulse, cpu_ce, that gates every CPU register, control FSM and test-memory write. All blocks then run on the raw board clock.
- Adds a runtime-programmable divide ratio, cycle step, instruction step, an address breakpoint, and a cycle counter for debug and seven-segment display.

Parameters:
DIV_W, 17, width of prescaler counter and div_ratio
ADDR_W, 16, width of CPU address compared for breakpoints ({memory_bus_h, memory_bus_l})
CYC_W, 32, width of executed-cycle counter

Ports:
clk  in  1  board clock
rst  in  1  asynchronous reset, active-high
div_ratio  in  DIV_W  cpu_ce rate = clk/(div_ratio+1)
mode  in  2  00 RUN, 01 STEP_CYCLE, 10 STEP_INSTR, 11 HALT
step_req  in  1  step button level (already debounced); rising edge used
bp_en  in  1  breakpoint enable
bp_addr  in  ADDR_W  breakpoint address
bp_clr  in  1  clears bp_hit and resumes (level, sampled each clk)
cpu_addr  in  ADDR_W  current CPU address bus
cpu_sync  in  1  high while CPU presents an opcode-fetch cycle
cpu_ce  out  1  one-clk enable pulse to CPU
halted  out  1  high in PAUSED
bp_hit  out  1  sticky breakpoint flag
cycle_count  out  CYC_W  number of cpu_ce pulses issued

Behaviour:
- Reset (async, immediate): prescaler cnt=0, state=PAUSED, cpu_ce=0, halted=1, bp_hit=0, cycle_count=0, skip=0, step edge register=0.
- Prescaler:
  - cnt free-runs in all states.
  - tick = (cnt >= div_ratio). On tick, cnt<=0; otherwise cnt<=cnt+1.
  - div_ratio=0 gives tick every clk.
  - Lowering div_ratio below the current cnt forces tick on the next clk; no hang and no wrap through 2^DIV_W.
- cpu_ce is registered: it is high for exactly one clk, in the cycle after the clk where tick and the issue condition were evaluated. It is never high two consecutive clks unless div_ratio=0.
- cycle_count increments by 1 in the same clk cpu_ce is driven high. It wraps modulo 2^CYC_W.
- FSM states: PAUSED, RUNNING, STEPPING.
  - PAUSED:
    - No cpu_ce.
    - mode=RUN and bp_hit=0 -> RUNNING.
    - mode=STEP_CYCLE or STEP_INSTR with a step_req rising edge -> STEPPING; the mode is latched as step_kind.
    - Step edges in RUN or HALT mode are ignored.
  - RUNNING:
    - On tick, issue cpu_ce unless a breakpoint condition holds.
    - Breakpoint condition: bp_en & cpu_sync & (cpu_addr==bp_addr) & !skip. When it holds at a tick: suppress ce, set bp_hit, go PAUSED.
    - mode!=RUN -> PAUSED on the next clk. A tick in that same clk is not issued.
  - STEPPING:
    - The first tick always issues ce.
    - STEP_CYCLE: go PAUSED after that one ce.
    - STEP_INSTR: keep issuing ce on each tick while cpu_sync=0. At the first tick with cpu_sync=1 after the first ce, suppress ce and go PAUSED, leaving the CPU stopped before the next opcode fetch.
    - Breakpoints are not checked while stepping.
    - mode=HALT aborts the step -> PAUSED, with no further ce.
    - Step edges during STEPPING are ignored.
- skip:
  - Set on any transition out of PAUSED.
  - Cleared on the first cpu_ce issued after that.
  - Purpose: resuming at a breakpoint address does not re-trigger immediately.
- bp_clr=1 clears bp_hit on the next clk. If mode=RUN, PAUSED -> RUNNING follows on the next evaluation. When bp_clr and a new breakpoint hit occur in the same clk, the hit wins and bp_hit stays 1.
- halted = (state==PAUSED), registered. It goes high the same clk the FSM enters PAUSED.
- Reset mid-pulse: cpu_ce drops immediately. The CPU is responsible for its own reset.

Test Plan:
- RUN, div_ratio=3, bp_en=0, 40 clks after reset release -> first cpu_ce within 5 clks, then every 4 clks; cycle_count=9 or 10 with consistent spacing; halted=0.
- RUN at div_ratio=1000, change to div_ratio=2 when cnt≈500 -> ce on next clk, then every 3 clks; no gap longer than 3 clks afterwards.
- bp_en=1, bp_addr=16'h0203; drive cpu_addr=16'h0203 with cpu_sync=1 at a tick -> no ce that tick, bp_hit=1, halted=1, ce count frozen. Pulse bp_clr -> RUNNING, next ce issued despite address still matching; bp_hit=0.
- STEP_CYCLE, three step_req edges 20 clks apart, div_ratio=0 -> exactly 3 ce total, cycle_count=3, halted=1 between steps.
- STEP_INSTR, cpu_sync pattern 1,0,0,1 on successive ticks -> 3 ce issued, suppressed at the 4th tick (sync=1), halted=1.
- Assert rst during RUNNING with cycle_count=57 -> cycle_count=0, cpu_ce=0, halted=1 asynchronously. With mode=RUN after release -> resumes running.
